input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 106 ++++++++++
 tb/tb_input_debouncer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a four-state debounce FSM.
// q, rise and fall are all registered. A new level is accepted only after it holds for CNT_MAX cycles.
module input_debouncer #(
    parameter int CNT_MAX = 4,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CNT_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CNT_LO    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            state <= STABLE_LO;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                STABLE_LO: begin
                    cnt <= '0;
                    if (s2) begin
                        // With CNT_MAX = 1 the first sample completes qualification.
                        if (CNT_MAX == 1) begin
                            state <= STABLE_HI;
                            q     <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            state <= CNT_HI;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                CNT_HI: begin
                    if (!s2) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        q     <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    cnt <= '0;
                    if (!s2) begin
                        if (CNT_MAX == 1) begin
                            state <= STABLE_LO;
                            q     <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            state <= CNT_LO;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                CNT_LO: begin
                    if (s2) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        q     <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a CNT_MAX=4 instance for the main scenarios and a CNT_MAX=1 instance.
module tb_input_debouncer;

    logic clk;
    logic reset;
    logic din;
    logic din1;
    logic q, rise, fall;
    logic q1, rise1, fall1;

    int checks = 0;
    int errors = 0;
    int rise_total = 0;
    int fall_total = 0;
    int both_total = 0;
    int consec_total = 0;
    logic prev_pulse = 1'b0;

    input_debouncer #(.CNT_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .din(din), .q(q), .rise(rise), .fall(fall)
    );

    input_debouncer #(.CNT_MAX(1), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .din(din1), .q(q1), .rise(rise1), .fall(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping sees the values present during the cycle ending at this edge.
    always @(posedge clk) begin
        if (rise) rise_total++;
        if (fall) fall_total++;
        if (rise && fall) both_total++;
        if ((rise || fall) && prev_pulse) consec_total++;
        prev_pulse = rise || fall;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        din   = 1'b0;
        din1  = 1'b0;

        // Reset state (t=2)
        #2;
        chk("rst_q", q, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_s2", dut.s2, 0);
        #6 reset = 1'b1;          // t=8

        // Clean rise: din=1 at t=12, edges 15..65, q at 65
        #4 din = 1'b1;            // t=12
        edge_n(5);                // t=56
        chk("rise_q_before", q, 0);
        chk("rise_cnt3", dut.cnt, 3);
        edge_n(1);                // t=66
        chk("rise_q", q, 1);
        chk("rise_pulse", rise, 1);
        chk("rise_nofall", fall, 0);
        chk("rise_cnt_clr", dut.cnt, 0);
        edge_n(1);                // t=76
        chk("rise_pulse_end", rise, 0);
        chk("rise_q_hold", q, 1);
        chk("rise_total1", rise_total, 1);
        chk("fall_total0", fall_total, 0);

        // Clean fall: din=0 at t=76, q falls at edge 135
        din = 1'b0;
        edge_n(4);                // t=116
        chk("fall_q_before", q, 1);
        chk("fall_cnt2", dut.cnt, 2);
        edge_n(2);                // t=136
        chk("fall_q", q, 0);
        chk("fall_pulse", fall, 1);
        chk("fall_norise", rise, 0);
        edge_n(1);                // t=146
        chk("fall_pulse_end", fall, 0);
        chk("fall_total1", fall_total, 1);

        // Glitch reject: din=1 for 20 units
        din = 1'b1;               // t=146
        #20 din = 1'b0;           // t=166
        edge_n(2);                // t=186
        chk("glitch_cnt2", dut.cnt, 2);
        chk("glitch_q_mid", q, 0);
        edge_n(7);                // t=256
        chk("glitch_q", q, 0);
        chk("glitch_cnt0", dut.cnt, 0);
        chk("glitch_rise_total", rise_total, 1);
        chk("glitch_fall_total", fall_total, 1);

        // Bounce then settle: s2 last becomes 1 at edge 315, q at 355
        din = 1'b1;               // t=256
        #10 din = 1'b0;           // t=266
        #10 din = 1'b1;           // t=276
        #10 din = 1'b0;           // t=286
        #10 din = 1'b1;           // t=296
        edge_n(5);                // t=346
        chk("bounce_q_before", q, 0);
        chk("bounce_rise_before", rise_total, 1);
        edge_n(1);                // t=356
        chk("bounce_q", q, 1);
        chk("bounce_rise", rise, 1);
        edge_n(1);                // t=366
        chk("bounce_rise_end", rise, 0);
        chk("bounce_rise_total", rise_total, 2);

        // Async reset during a CNT_LO count
        din = 1'b0;               // t=366
        edge_n(4);                // t=406
        chk("arst_pre_cnt", dut.cnt, 2);
        chk("arst_pre_q", q, 1);
        #2;                       // t=408
        reset = 1'b0;
        din   = 1'b1;
        #1;                       // t=409
        chk("arst_q", q, 0);
        chk("arst_cnt", dut.cnt, 0);
        chk("arst_rise", rise, 0);
        chk("arst_fall", fall, 0);
        chk("arst_s2", dut.s2, 0);
        #3 reset = 1'b1;          // t=412
        edge_n(5);                // t=456
        chk("arst_q_before", q, 0);
        edge_n(1);                // t=466
        chk("arst_q_back", q, 1);
        chk("arst_rise_back", rise, 1);
        chk("arst_fall_total", fall_total, 1);

        // CNT_MAX=1: s1 captures at 475, q1 at 495
        #2 din1 = 1'b1;           // t=468
        edge_n(2);                // t=486
        chk("c1_q_before", q1, 0);
        edge_n(1);                // t=496
        chk("c1_q", q1, 1);
        chk("c1_rise", rise1, 1);
        chk("c1_fall", fall1, 0);
        edge_n(1);                // t=506
        chk("c1_rise_end", rise1, 0);

        chk("total_rise", rise_total, 3);
        chk("no_both", both_total, 0);
        chk("no_consec", consec_total, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
